vdot_issuer: RTL and testbench

VDOT_ISSUER -- requirements
Module: vdot_issuer

---
 rtl/vdot_pkg.sv | 14 +
 rtl/vdot_acc.sv | 53 +++++
 rtl/vdot_issuer.sv | 110 +++++++++++
 tb/tb_vdot_issuer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdot_pkg.sv
// Shared definitions for the vector dot-product issuer: FSM state encoding and EXEC length.
package vdot_pkg;

    localparam int VDOT_LAT = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DONE  = 3'd4
    } vdot_state_e;

endpackage

// File: rtl/vdot_acc.sv
// 32-bit unsigned accumulator with synchronous clear.
// Macro VDOT_ISSUER_SAT_EN selects clamping at 0xFFFFFFFF with a sticky overflow flag; otherwise it wraps.
module vdot_acc
    import vdot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add_en,
    input  logic [31:0] din,
    output logic [31:0] acc,
    output logic        ovf
);

    logic [31:0] acc_reg;

`ifdef VDOT_ISSUER_SAT_EN
    logic [32:0] sum;
    logic        ovf_reg;

    assign sum = {1'b0, acc_reg} + {1'b0, din};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
        end else if (add_en) begin
            // Carry-out pins the sum at all-ones; once saturated it stays there.
            if (sum[32]) begin
                acc_reg <= '1;
                ovf_reg <= 1'b1;
            end else begin
                acc_reg <= sum[31:0];
            end
        end
    end

    assign ovf = ovf_reg;
`else
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_reg <= '0;
        end else if (add_en) begin
            acc_reg <= acc_reg + din;
        end
    end

    assign ovf = 1'b0;
`endif

    assign acc = acc_reg;

endmodule

// File: rtl/vdot_issuer.sv
// Walks two operand vectors in memory, feeds each word pair to a 3-cycle dot-product unit and sums results.
// Macro VDOT_ISSUER_SAT_EN (handled in vdot_acc) turns on saturating accumulation.
module vdot_issuer
    import vdot_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       a_rdata,
    input  logic [31:0]       b_rdata,
    output logic              vd_en,
    output logic [31:0]       vd_a,
    output logic [31:0]       vd_b,
    input  logic [31:0]       vd_res,
    output logic              busy,
    output logic              done,
    output logic [31:0]       acc,
    output logic              ovf
);

    vdot_state_e       state_reg, state_next;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  i_reg;
    logic [ADDR_W-1:0] base_a_reg, base_b_reg;
    logic [1:0]        cnt_reg;
    logic [31:0]       opa_reg, opb_reg;
    logic [LEN_W:0]    i_inc;
    logic              accept;
    logic              exec_last;
    logic              last_elem;

    assign accept    = (state_reg == ST_IDLE) && start;
    assign exec_last = (state_reg == ST_EXEC) && (cnt_reg == 2'(VDOT_LAT - 1));
    assign i_inc     = {1'b0, i_reg} + 1'b1;
    assign last_elem = (i_inc == {1'b0, len_reg});

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = (len == '0) ? ST_DONE : ST_FETCH;
            ST_FETCH: state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_EXEC;
            ST_EXEC:  if (exec_last) state_next = last_elem ? ST_DONE : ST_FETCH;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            len_reg    <= '0;
            i_reg      <= '0;
            base_a_reg <= '0;
            base_b_reg <= '0;
            cnt_reg    <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                len_reg    <= len;
                base_a_reg <= base_a;
                base_b_reg <= base_b;
                i_reg      <= '0;
            end
            if (state_reg == ST_LOAD) begin
                opa_reg <= a_rdata;
                opb_reg <= b_rdata;
                cnt_reg <= '0;
            end
            if (state_reg == ST_EXEC) begin
                if (exec_last) begin
                    i_reg <= i_inc[LEN_W-1:0];
                end else begin
                    cnt_reg <= cnt_reg + 2'd1;
                end
            end
        end
    end

    // Addresses are pure functions of the latched bases and index, so they wrap at 2^ADDR_W for free.
    assign a_addr = base_a_reg + ADDR_W'(i_reg);
    assign b_addr = base_b_reg + ADDR_W'(i_reg);

    assign vd_en = (state_reg == ST_EXEC);
    assign vd_a  = opa_reg;
    assign vd_b  = opb_reg;
    assign busy  = (state_reg != ST_IDLE);
    assign done  = (state_reg == ST_DONE);

    vdot_acc u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .add_en (exec_last),
        .din    (vd_res),
        .acc    (acc),
        .ovf    (ovf)
    );

endmodule

// File: tb/tb_vdot_issuer.sv
// Self-checking bench for vdot_issuer: memory and dot-unit stubs plus a cycle-timeline reference model.
module tb_vdot_issuer;

    localparam int AW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [LW-1:0] len;
    logic [AW-1:0] base_a, base_b, a_addr, b_addr;
    logic [31:0]   a_rdata, b_rdata, vd_a, vd_b, vd_res, acc;
    logic          vd_en, busy, done, ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vdot_issuer #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .base_a(base_a), .base_b(base_b), .a_addr(a_addr), .b_addr(b_addr),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .vd_en(vd_en), .vd_a(vd_a), .vd_b(vd_b), .vd_res(vd_res),
        .busy(busy), .done(done), .acc(acc), .ovf(ovf)
    );

    // Synchronous-read operand memories
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    always @(posedge clk) begin
        a_rdata <= mem_a[a_addr];
        b_rdata <= mem_b[b_addr];
    end

    // Dot-unit stub: either a per-element result table or the low word of a*b
    logic        use_tab = 1'b0;
    logic [31:0] res_tab [16];
    int          tab_base = 0;
    int          en_falls = 0;
    logic        en_d = 1'b0;
    always @(posedge clk) begin
        en_d <= vd_en;
        if (en_d && !vd_en) en_falls <= en_falls + 1;
    end
    assign vd_res = use_tab ? res_tab[4'(en_falls - tab_base)] : vd_a * vd_b;

    task automatic test_vector(input string name, input int n, input logic [7:0] ba,
                               input logic [7:0] bb, input bit tab, input bit poke);
        logic [31:0] exp_acc, r;
        logic        exp_ovf;
        logic [32:0] s;
        int          e, ph, ia, ib, last_a, last_b;
        bit          exp_en;
        exp_acc = '0;
        exp_ovf = 1'b0;
        for (int j = 0; j < n; j++) begin
            ia = (int'(ba) + j) & 255;
            ib = (int'(bb) + j) & 255;
            r  = tab ? res_tab[j] : mem_a[ia] * mem_b[ib];
            s  = {1'b0, exp_acc} + {1'b0, r};
`ifdef VDOT_ISSUER_SAT_EN
            if (s[32]) begin exp_acc = '1; exp_ovf = 1'b1; end
            else exp_acc = s[31:0];
`else
            exp_acc = s[31:0];
`endif
        end
        last_a   = (int'(ba) + n - 1) & 255;
        last_b   = (int'(bb) + n - 1) & 255;
        use_tab  = tab;
        tab_base = en_falls;
        start = 1'b1; len = LW'(n); base_a = ba; base_b = bb;
        @(posedge clk); #1;
        start = 1'b0; len = LW'($urandom); base_a = AW'($urandom); base_b = AW'($urandom);
        for (int k = 1; k <= 5 * n + 2; k++) begin
            e  = (k - 1) / 5;
            ph = (k - 1) % 5;
            ia = (int'(ba) + e) & 255;
            ib = (int'(bb) + e) & 255;
            exp_en = (k <= 5 * n) && (ph >= 2);
            checks++;
            if (vd_en !== exp_en) begin
                errors++;
                $display("FAIL %s vd_en k=%0d got %b want %b", name, k, vd_en, exp_en);
            end
            checks++;
            if (busy !== (k <= 5 * n + 1)) begin
                errors++;
                $display("FAIL %s busy k=%0d got %b want %b", name, k, busy, (k <= 5 * n + 1));
            end
            checks++;
            if (done !== (k == 5 * n + 1)) begin
                errors++;
                $display("FAIL %s done k=%0d got %b want %b", name, k, done, (k == 5 * n + 1));
            end
            if (k <= 5 * n && ph == 0) begin
                checks++;
                if (a_addr !== AW'(ia) || b_addr !== AW'(ib)) begin
                    errors++;
                    $display("FAIL %s addr k=%0d got %h/%h want %h/%h", name, k, a_addr, b_addr, AW'(ia), AW'(ib));
                end
            end
            if (exp_en) begin
                checks++;
                if (vd_a !== mem_a[ia] || vd_b !== mem_b[ib]) begin
                    errors++;
                    $display("FAIL %s operands k=%0d got %h/%h want %h/%h", name, k, vd_a, vd_b, mem_a[ia], mem_b[ib]);
                end
            end
            if (k == 5 * n + 2 && n > 0) begin
                checks++;
                if (vd_a !== mem_a[last_a] || vd_b !== mem_b[last_b]) begin
                    errors++;
                    $display("FAIL %s operand_hold got %h/%h want %h/%h", name, vd_a, vd_b, mem_a[last_a], mem_b[last_b]);
                end
            end
            if (k >= 5 * n + 1) begin
                checks++;
                if (acc !== exp_acc || ovf !== exp_ovf) begin
                    errors++;
                    $display("FAIL %s acc k=%0d got %h/%b want %h/%b", name, k, acc, ovf, exp_acc, exp_ovf);
                end
            end
            if (poke && n > 0 && k == 3) begin
                start = 1'b1; len = LW'($urandom_range(1, 9));
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        $display("txn %s len=%0d base_a=%h base_b=%h acc=%h ovf=%b", name, n, ba, bb, acc, ovf);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; len = 8'd5; base_a = 8'h33; base_b = 8'h44;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, vd_en, ovf} !== 4'b0 || acc !== '0 || vd_a !== '0 || vd_b !== '0
            || a_addr !== '0 || b_addr !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b en=%b acc=%h ovf=%b a=%h b=%h aa=%h ba=%h want all 0",
                     busy, done, vd_en, acc, ovf, vd_a, vd_b, a_addr, b_addr);
        end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored busy got %b want 0", busy);
        end
        $display("txn reset busy=%b acc=%h", busy, acc);
    endtask

    task automatic test_single();
        mem_a[0] = 32'h1111_1111; mem_b[0] = 32'h2222_2222; res_tab[0] = 32'h10;
        test_vector("single", 1, 8'h00, 8'h00, 1'b1, 1'b0);
        checks++;
        if (acc !== 32'h10) begin
            errors++;
            $display("FAIL single_acc got %h want 00000010", acc);
        end
    endtask

    task automatic test_four();
        for (int j = 0; j < 4; j++) res_tab[j] = 32'(j + 1);
        test_vector("four", 4, 8'h10, 8'h20, 1'b1, 1'b0);
        checks++;
        if (acc !== 32'd10) begin
            errors++;
            $display("FAIL four_acc got %h want 0000000a", acc);
        end
    endtask

    task automatic test_len0();
        test_vector("len0", 0, 8'h05, 8'h06, 1'b0, 1'b0);
        checks++;
        if (acc !== 32'h0) begin
            errors++;
            $display("FAIL len0_acc got %h want 00000000", acc);
        end
    endtask

    task automatic test_addr_wrap();
        test_vector("wrap", 3, 8'hFE, 8'h7F, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        res_tab[0] = 32'hFFFF_FFF0; res_tab[1] = 32'h20;
        test_vector("overflow", 2, 8'h40, 8'h50, 1'b1, 1'b0);
        checks++;
`ifdef VDOT_ISSUER_SAT_EN
        if (acc !== 32'hFFFF_FFFF || ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sat got %h/%b want ffffffff/1", acc, ovf);
        end
`else
        if (acc !== 32'h10 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL overflow_wrap got %h/%b want 00000010/0", acc, ovf);
        end
`endif
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 8; t++)
            test_vector("random", int'($urandom_range(1, 8)), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    endtask

    task automatic test_reset_abort();
        use_tab = 1'b0;
        start = 1'b1; len = 8'd2; base_a = 8'h80; base_b = 8'h90;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL abort_done_early k=%0d got %b want 0", k, done);
            end
            if (k == 9) begin
                checks++;
                if (vd_en !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_in_exec got %b want 1", vd_en);
                end
            end
            start = (k == 4) || (k == 9);
            len   = 8'd1;
            rst   = (k == 9);
            @(posedge clk); #1;
        end
        checks++;
        if ({busy, done, vd_en, ovf} !== 4'b0 || acc !== '0 || vd_a !== '0 || vd_b !== '0
            || a_addr !== '0 || b_addr !== '0) begin
            errors++;
            $display("FAIL abort_reset_state got busy=%b done=%b en=%b acc=%h ovf=%b a=%h b=%h aa=%h ba=%h want all 0",
                     busy, done, vd_en, acc, ovf, vd_a, vd_b, a_addr, b_addr);
        end
        rst = 1'b0; start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet k=%0d busy/done got %b/%b want 0/0", k, busy, done);
            end
        end
        $display("txn reset_abort busy=%b done=%b acc=%h", busy, done, acc);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; base_a = '0; base_b = '0;
        for (int j = 0; j < 256; j++) begin
            mem_a[j] = $urandom;
            mem_b[j] = $urandom;
        end
        for (int j = 0; j < 16; j++) res_tab[j] = '0;
        test_reset();
        test_single();
        test_four();
        test_len0();
        test_addr_wrap();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
